// File: rtl/lfsr_matrix_scan_if.sv
// Bus bundle for lfsr_matrix_scan: LFSR control inputs and LED matrix drive outputs.
// With LFSR_MATRIX_DIM_EN defined the bundle also carries the 4-bit brightness input.
interface lfsr_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                   i_RUN;
    logic                   i_SEED_DV;
    logic [ROWS*COLS-1:0]   i_SEED;
`ifdef LFSR_MATRIX_DIM_EN
    logic [3:0]             i_BRIGHT;
`endif
    logic [ROWS-1:0]        o_ROWS;
    logic [COLS-1:0]        o_COLS;
    logic [2:0]             o_LED;
    logic                   o_STEP;

    modport slave (
`ifdef LFSR_MATRIX_DIM_EN
        input  i_BRIGHT,
`endif
        input  i_RUN,
        input  i_SEED_DV,
        input  i_SEED,
        output o_ROWS,
        output o_COLS,
        output o_LED,
        output o_STEP
    );

    modport master (
`ifdef LFSR_MATRIX_DIM_EN
        output i_BRIGHT,
`endif
        output i_RUN,
        output i_SEED_DV,
        output i_SEED,
        input  o_ROWS,
        input  o_COLS,
        input  o_LED,
        input  o_STEP
    );
endinterface

// File: rtl/lfsr_matrix_scan.sv
// lfsr_matrix_scan: Fibonacci XNOR LFSR (16/32/64 bits) shown on a multiplexed
// ROWS x COLS LED matrix. Scan and step rates are clock enables from free-running
// dividers. A frame buffer is captured at the end of each scan frame so the
// displayed picture never tears.
// Optional feature macro: LFSR_MATRIX_DIM_EN adds i_BRIGHT and a 4-bit PWM that
// blanks the row drive whenever pwm >= i_BRIGHT.
module lfsr_matrix_scan #(
    parameter int     ROWS     = 8,
    parameter int     COLS     = 8,
    parameter int     SCAN_DIV = 65536,
    parameter longint STEP_DIV = 64'd33554432
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    lfsr_matrix_scan_if.slave   bus
);
    localparam int N      = ROWS * COLS;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int ROW_W  = $clog2(ROWS);

    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 32'sd1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_DIV - 64'sd1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 32'sd1);

    // Tap masks (bit k-1 set for 1-indexed tap k)
    localparam logic [63:0] TAPS_64 =
        (N == 32'sd16) ? 64'h0000_0000_0000_D008 :
        (N == 32'sd32) ? 64'h0000_0000_8020_0003 :
                         64'hD800_0000_0000_0000;
    localparam logic [N-1:0] TAP_MASK = TAPS_64[N-1:0];

    generate
        if (!(N == 32'sd16 || N == 32'sd32 || N == 32'sd64)) begin : g_bad_size
            $error("lfsr_matrix_scan: ROWS*COLS must be 16, 32 or 64");
        end
    endgenerate

    // Even parity of a vector
    function automatic logic parity_f(input logic [N-1:0] v);
        return ^v;
    endfunction

    // One XNOR Fibonacci step; all-ones maps onto itself (lock-up)
    function automatic logic [N-1:0] lfsr_next_f(input logic [N-1:0] q);
        return {q[N-2:0], ~parity_f(q & TAP_MASK)};
    endfunction

    logic [SCAN_W-1:0] scan_cnt_r;
    logic [STEP_W-1:0] step_cnt_r;
    logic [N-1:0]      lfsr_r;
    logic [N-1:0]      frame_r;
    logic [ROW_W-1:0]  row_r;
    logic              scan_tick_d_r;
    logic [ROWS-1:0]   row_sel_r;
    logic [COLS-1:0]   cols_r;
    logic              step_r;

    logic              scan_tick_s;
    logic              step_tick_s;
    logic [ROWS-1:0]   row_onehot_s;
    logic [COLS-1:0]   row_bits_s;

    assign scan_tick_s  = (scan_cnt_r == SCAN_MAX);
    assign step_tick_s  = (step_cnt_r == STEP_MAX);
    assign row_onehot_s = ROWS'(1'b1) << row_r;

    // Select the current row's slice of the frame buffer
    always_comb begin
        row_bits_s = frame_r[int'(row_r) * COLS +: COLS];
    end

    // Scan divider, row index and end-of-frame capture of the LFSR
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            scan_cnt_r    <= '0;
            row_r         <= '0;
            frame_r       <= '0;
            scan_tick_d_r <= 1'b0;
        end else begin
            scan_tick_d_r <= scan_tick_s;
            if (scan_tick_s) begin
                scan_cnt_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r   <= '0;
                    frame_r <= lfsr_r;
                end else begin
                    row_r   <= row_r + 1'b1;
                    frame_r <= frame_r;
                end
            end else begin
                scan_cnt_r <= scan_cnt_r + 1'b1;
                row_r      <= row_r;
                frame_r    <= frame_r;
            end
        end
    end

    // Row/column drive refreshed one clock after each scan tick
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            row_sel_r <= '0;
            cols_r    <= '1;
        end else if (scan_tick_d_r) begin
            row_sel_r <= row_onehot_s;
            cols_r    <= ~row_bits_s;
        end else begin
            row_sel_r <= row_sel_r;
            cols_r    <= cols_r;
        end
    end

    // Step divider, LFSR load/advance (seed wins) and the follow-up step pulse
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            step_cnt_r <= '0;
            lfsr_r     <= '0;
            step_r     <= 1'b0;
        end else begin
            step_cnt_r <= step_tick_s ? '0 : (step_cnt_r + 1'b1);
            if (bus.i_SEED_DV) begin
                lfsr_r <= bus.i_SEED;
            end else if (step_tick_s && bus.i_RUN) begin
                lfsr_r <= lfsr_next_f(lfsr_r);
            end else begin
                lfsr_r <= lfsr_r;
            end
            step_r <= bus.i_SEED_DV | (step_tick_s & bus.i_RUN);
        end
    end

`ifdef LFSR_MATRIX_DIM_EN
    logic [3:0]      pwm_r;
    logic [ROWS-1:0] rows_gated_r;
    logic [ROWS-1:0] sel_next_s;

    assign sel_next_s = scan_tick_d_r ? row_onehot_s : row_sel_r;

    // Free-running PWM phase and brightness-gated row drive
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            pwm_r        <= 4'd0;
            rows_gated_r <= '0;
        end else begin
            pwm_r <= pwm_r + 4'd1;
            if (pwm_r < bus.i_BRIGHT) begin
                rows_gated_r <= sel_next_s;
            end else begin
                rows_gated_r <= '0;
            end
        end
    end

    assign bus.o_ROWS = rows_gated_r;
`else
    assign bus.o_ROWS = row_sel_r;
`endif

    assign bus.o_COLS = cols_r;
    assign bus.o_STEP = step_r;
    assign bus.o_LED  = lfsr_r[2:0];
endmodule
